// File: rtl/sw_alloc_rr_lock.sv
// Packet-locked round-robin switch allocator: zero-latency grants, per-output wormhole lock.
// Define SW_ALLOC_ERR_CHK_EN to build the sticky protocol-error checker driving err.
module sw_alloc_rr_lock #(
    parameter int P            = 5,
    parameter int SELF_LOOP_EN = 0,
    localparam int P_1         = (SELF_LOOP_EN != 0) ? P : P - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P*P_1-1:0]   dest_port_req_all,
    input  logic [P-1:0]       hdr_flag_all,
    input  logic [P-1:0]       tail_flag_all,
    input  logic [P-1:0]       out_ready_all,
    output logic [P*P_1-1:0]   granted_dest_port_all,
    output logic [P-1:0]       in_grant_all,
    output logic [P-1:0]       out_lock_all,
    output logic               err
);

    localparam int W = (P > 1) ? $clog2(P) : 1;

    logic [P-1:0]          lock_r;
    logic [P-1:0][W-1:0]   owner_r;
    logic [P-1:0][W-1:0]   ptr_r;

    logic [P-1:0][P-1:0]   req_s;      // [output][input]
    logic [P-1:0][P-1:0]   gnt_s;      // [output][input]
    logic [P-1:0]          win_vld_s;
    logic [P-1:0][W-1:0]   win_idx_s;
    logic [P*P_1-1:0]      granted_s;
    logic [P-1:0]          in_grant_s;

    // Local bit of output o inside the request slice of input j (own port folded out when no self loop).
    function automatic int local_bit(input int j, input int o);
        if (SELF_LOOP_EN != 0) begin
            return o;
        end else if (o > j) begin
            return o - 1;
        end else if (o < j) begin
            return o;
        end else begin
            return 0;
        end
    endfunction

    function automatic logic port_valid(input int j, input int o);
        return (SELF_LOOP_EN != 0) || (o != j);
    endfunction

    function automatic logic [W-1:0] next_idx(input logic [W-1:0] k);
        if (int'(k) == P - 1) begin
            return {W{1'b0}};
        end else begin
            return k + W'(1);
        end
    endfunction

    // Expand the per-input compressed requests into a full output-by-input matrix.
    always_comb begin
        req_s = {(P*P){1'b0}};
        for (int o = 0; o < P; o++) begin
            for (int j = 0; j < P; j++) begin
                if (port_valid(j, o)) begin
                    req_s[o][j] = dest_port_req_all[j*P_1 + local_bit(j, o)];
                end else begin
                    req_s[o][j] = 1'b0;
                end
            end
        end
    end

    // Per-output arbitration: owner-only while locked, rotating header search otherwise.
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        win_vld_s = {P{1'b0}};
        win_idx_s = {(P*W){1'b0}};
        gnt_s     = {(P*P){1'b0}};
        for (int o = 0; o < P; o++) begin
            if (lock_r[o]) begin
                win_idx_s[o] = owner_r[o];
                win_vld_s[o] = out_ready_all[o] && req_s[o][owner_r[o]];
            end else begin
                found = 1'b0;
                for (int i = 0; i < P; i++) begin
                    idx = int'(ptr_r[o]) + i;
                    if (idx >= P) begin
                        idx = idx - P;
                    end else begin
                        idx = idx;
                    end
                    if (!found && req_s[o][idx] && hdr_flag_all[idx]) begin
                        found        = 1'b1;
                        win_idx_s[o] = idx[W-1:0];
                    end else begin
                        found = found;
                    end
                end
                win_vld_s[o] = found && out_ready_all[o];
            end
            for (int j = 0; j < P; j++) begin
                gnt_s[o][j] = win_vld_s[o] && (win_idx_s[o] == W'(j));
            end
        end
    end

    // Fold the grant matrix back into the request encoding and the per-input consume strobe.
    always_comb begin
        granted_s  = {(P*P_1){1'b0}};
        in_grant_s = {P{1'b0}};
        for (int j = 0; j < P; j++) begin
            for (int o = 0; o < P; o++) begin
                if (port_valid(j, o)) begin
                    granted_s[j*P_1 + local_bit(j, o)] = gnt_s[o][j];
                    in_grant_s[j] = in_grant_s[j] | gnt_s[o][j];
                end else begin
                    in_grant_s[j] = in_grant_s[j];
                end
            end
        end
    end

    assign granted_dest_port_all = reset ? {(P*P_1){1'b0}} : granted_s;
    assign in_grant_all          = reset ? {P{1'b0}} : in_grant_s;
    assign out_lock_all          = reset ? {P{1'b0}} : lock_r;

    // Lock / owner / pointer update; only a granted flit changes an output's state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_r  <= {P{1'b0}};
            owner_r <= {(P*W){1'b0}};
            ptr_r   <= {(P*W){1'b0}};
        end else begin
            for (int o = 0; o < P; o++) begin
                if (win_vld_s[o]) begin
                    if (hdr_flag_all[win_idx_s[o]]) begin
                        lock_r[o] <= ~tail_flag_all[win_idx_s[o]];
                        ptr_r[o]  <= next_idx(win_idx_s[o]);
                        if (!tail_flag_all[win_idx_s[o]]) begin
                            owner_r[o] <= win_idx_s[o];
                        end else begin
                            owner_r[o] <= owner_r[o];
                        end
                    end else if (tail_flag_all[win_idx_s[o]]) begin
                        lock_r[o] <= 1'b0;
                    end else begin
                        lock_r[o] <= lock_r[o];
                    end
                end else begin
                    lock_r[o] <= lock_r[o];
                end
            end
        end
    end

`ifdef SW_ALLOC_ERR_CHK_EN
    logic err_r;
    logic err_hit_s;

    // Protocol violations: malformed slice, headless flit to a free port, header from the current owner.
    always_comb begin
        logic [P_1-1:0] slice;
        slice     = {P_1{1'b0}};
        err_hit_s = 1'b0;
        for (int j = 0; j < P; j++) begin
            slice = dest_port_req_all[j*P_1 +: P_1];
            if ((slice & (slice - P_1'(1))) != {P_1{1'b0}}) begin
                err_hit_s = 1'b1;
            end else begin
                err_hit_s = err_hit_s;
            end
        end
        for (int o = 0; o < P; o++) begin
            for (int j = 0; j < P; j++) begin
                if (req_s[o][j] && !hdr_flag_all[j] && !lock_r[o]) begin
                    err_hit_s = 1'b1;
                end else begin
                    err_hit_s = err_hit_s;
                end
            end
            if (lock_r[o] && req_s[o][owner_r[o]] && hdr_flag_all[owner_r[o]]) begin
                err_hit_s = 1'b1;
            end else begin
                err_hit_s = err_hit_s;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_hit_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_alloc_rr_lock.sv
// Self-checking bench for sw_alloc_rr_lock: vector table, corner sequences, random traffic vs. a reference model.
module tb_sw_alloc_rr_lock;

    localparam int P   = 5;
    localparam int P_1 = 4;
    localparam int NW  = P * P_1;

`ifdef SW_ALLOC_ERR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NW-1:0] req = '0;
    logic [P-1:0]  hdr = '0, tail = '0, ready = '0;
    logic [NW-1:0] gnt;
    logic [P-1:0]  ig, lk;
    logic          err;

    logic [P*P-1:0] req2 = '0;
    logic [P-1:0]   hdr2 = '0, tail2 = '0, ready2 = '0;
    logic [P*P-1:0] gnt2;
    logic [P-1:0]   ig2, lk2;
    logic           err2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_alloc_rr_lock #(.P(P), .SELF_LOOP_EN(0)) dut (
        .clk(clk), .reset(reset), .dest_port_req_all(req), .hdr_flag_all(hdr),
        .tail_flag_all(tail), .out_ready_all(ready), .granted_dest_port_all(gnt),
        .in_grant_all(ig), .out_lock_all(lk), .err(err)
    );

    sw_alloc_rr_lock #(.P(P), .SELF_LOOP_EN(1)) dut_sl (
        .clk(clk), .reset(reset), .dest_port_req_all(req2), .hdr_flag_all(hdr2),
        .tail_flag_all(tail2), .out_ready_all(ready2), .granted_dest_port_all(gnt2),
        .in_grant_all(ig2), .out_lock_all(lk2), .err(err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [NW-1:0] req;
        logic [P-1:0]  hdr;
        logic [P-1:0]  tail;
        logic [P-1:0]  rdy;
        logic [NW-1:0] gnt;
        logic [P-1:0]  ig;
        logic [P-1:0]  lk;
    } vec_t;
    vec_t tbl[13];

    // Reference model: arrays per output, rotating search by distance from the pointer.
    int dst[P];
    int m_lock[P], m_owner[P], m_ptr[P];
    bit m_err;
    int win[P];
    int g_len[P], g_sent[P], g_dst[P];

    function automatic int pos(input int j, input int o);
        return j * P_1 + ((o > j) ? o - 1 : o);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
            g_len[o] = 0; g_sent[o] = 0; g_dst[o] = 0; dst[o] = -1;
        end
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        int bd, d;
        for (int o = 0; o < P; o++) begin
            win[o] = -1;
            if (m_lock[o] != 0) begin
                if (dst[m_owner[o]] == o && ready[o]) win[o] = m_owner[o];
            end else if (ready[o]) begin
                bd = P;
                for (int j = 0; j < P; j++) begin
                    if (dst[j] == o && hdr[j]) begin
                        d = (j - m_ptr[o] + P) % P;
                        if (d < bd) begin bd = d; win[o] = j; end
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        int k;
        for (int o = 0; o < P; o++) begin
            for (int j = 0; j < P; j++)
                if (CHK && dst[j] == o && !hdr[j] && m_lock[o] == 0) m_err = 1'b1;
            if (CHK && m_lock[o] != 0 && dst[m_owner[o]] == o && hdr[m_owner[o]]) m_err = 1'b1;
            if (win[o] >= 0) begin
                k = win[o];
                if (hdr[k] && !tail[k]) begin
                    m_lock[o] = 1; m_owner[o] = k; m_ptr[o] = (k + 1) % P;
                end else if (hdr[k]) begin
                    m_lock[o] = 0; m_ptr[o] = (k + 1) % P;
                end else if (tail[k]) begin
                    m_lock[o] = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0; hdr = '0; tail = '0; ready = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NW-1:0] eg;
        logic [P-1:0]  eig, elk;

        tbl[0]  = '{20'h01110, 5'b01110, 5'b01110, 5'b11111, 20'h00010, 5'b00010, 5'b00000};
        tbl[1]  = '{20'h01110, 5'b01110, 5'b01110, 5'b11111, 20'h00100, 5'b00100, 5'b00000};
        tbl[2]  = '{20'h01110, 5'b01110, 5'b01110, 5'b11111, 20'h01000, 5'b01000, 5'b00000};
        tbl[3]  = '{20'h00008, 5'b00001, 5'b00001, 5'b11111, 20'h00008, 5'b00001, 5'b00000};
        tbl[4]  = '{20'h00808, 5'b00101, 5'b00000, 5'b11111, 20'h00800, 5'b00100, 5'b00000};
        tbl[5]  = '{20'h00808, 5'b00001, 5'b00000, 5'b11111, 20'h00800, 5'b00100, 5'b10000};
        tbl[6]  = '{20'h00808, 5'b00001, 5'b00000, 5'b11111, 20'h00800, 5'b00100, 5'b10000};
        tbl[7]  = '{20'h00808, 5'b00001, 5'b00100, 5'b11111, 20'h00800, 5'b00100, 5'b10000};
        tbl[8]  = '{20'h00008, 5'b00001, 5'b00000, 5'b11111, 20'h00008, 5'b00001, 5'b00000};
        tbl[9]  = '{20'h00008, 5'b00000, 5'b00001, 5'b11111, 20'h00008, 5'b00001, 5'b10000};
        tbl[10] = '{20'h00040, 5'b00010, 5'b00010, 5'b10111, 20'h00000, 5'b00000, 5'b00000};
        tbl[11] = '{20'h00040, 5'b00010, 5'b00010, 5'b10111, 20'h00000, 5'b00000, 5'b00000};
        tbl[12] = '{20'h00040, 5'b00010, 5'b00010, 5'b11111, 20'h00040, 5'b00010, 5'b00000};

        // Reset state with requests present.
        req = 20'h01110; hdr = '1; ready = '1;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ig", 32'(ig), 32'h0);
        check("rst_lock", 32'(lk), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        do_reset();

        // Vector table: round-robin rotation, wormhole lock, back-pressure.
        for (int r = 0; r < 13; r++) begin
            @(negedge clk);
            req = tbl[r].req; hdr = tbl[r].hdr; tail = tbl[r].tail; ready = tbl[r].rdy;
            #1;
            check($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
            check($sformatf("tbl%0d_ig", r), 32'(ig), 32'(tbl[r].ig));
            check($sformatf("tbl%0d_lock", r), 32'(lk), 32'(tbl[r].lk));
        end

        // Reset in the middle of a packet from input 3 to output 1.
        do_reset();
        @(negedge clk);
        req = 20'h02000; hdr = 5'b01000; tail = '0; ready = '1;
        #1 check("mid_hdr_gnt", 32'(gnt), 32'h02000);
        @(negedge clk);
        hdr = '0;
        #1 check("mid_body_lock", 32'(lk), 32'h02);
        check("mid_body_gnt", 32'(gnt), 32'h02000);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_ig", 32'(ig), 32'h0);
        check("mid_rst_lock", 32'(lk), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_rst_body_gnt", 32'(gnt), 32'h0);
        check("post_rst_body_ig", 32'(ig), 32'h0);
        @(negedge clk);
        req = '0;
        #1 check("post_rst_err", 32'(err), 32'(CHK));

        // Malformed request slice from input 0.
        do_reset();
        @(negedge clk);
        req = 20'h00003; hdr = 5'b00001; tail = '0; ready = '0;
        #1 check("bad_slice_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        req = '0; hdr = '0; ready = '1;
        #1 check("bad_slice_err", 32'(err), 32'(CHK));
        repeat (3) @(negedge clk);
        #1 check("bad_slice_err_sticky", 32'(err), 32'(CHK));
        do_reset();
        #1 check("err_cleared", 32'(err), 32'h0);

        // Self-loop instance: inputs 0 and 2 both want output 2.
        @(negedge clk);
        req2 = 25'h0001004; hdr2 = 5'b00101; tail2 = 5'b00101; ready2 = '1;
        #1 check("sl_gnt_in0", 32'(gnt2), 32'h0000004);
        check("sl_ig_in0", 32'(ig2), 32'h01);
        @(negedge clk);
        req2 = 25'h0001000; hdr2 = 5'b00100; tail2 = 5'b00100;
        #1 check("sl_gnt_in2", 32'(gnt2), 32'h0001000);
        check("sl_ig_in2", 32'(ig2), 32'h04);
        @(negedge clk);
        req2 = '0; hdr2 = '0; tail2 = '0;

        // Random legal packet traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req = '0; hdr = '0; tail = '0;
            for (int o = 0; o < P; o++) ready[o] = ($urandom % 4) != 0;
            for (int j = 0; j < P; j++) begin
                dst[j] = -1;
                if (g_len[j] == 0 && ($urandom % 3) == 0) begin
                    g_dst[j] = (j + 1 + int'($urandom % (P - 1))) % P;
                    g_len[j] = 1 + int'($urandom % 4);
                    g_sent[j] = 0;
                end
                if (g_len[j] != 0 && (g_sent[j] == 0 || ($urandom % 4) != 0)) begin
                    dst[j] = g_dst[j];
                    hdr[j] = (g_sent[j] == 0);
                    tail[j] = (g_sent[j] == g_len[j] - 1);
                    req[pos(j, dst[j])] = 1'b1;
                end
            end
            #1;
            model_eval();
            eg = '0; eig = '0;
            for (int o = 0; o < P; o++) begin
                elk[o] = (m_lock[o] != 0);
                if (win[o] >= 0) begin
                    eg[pos(win[o], o)] = 1'b1;
                    eig[win[o]] = 1'b1;
                end
            end
            check("rnd_gnt", 32'(gnt), 32'(eg));
            check("rnd_ig", 32'(ig), 32'(eig));
            check("rnd_lock", 32'(lk), 32'(elk));
            check("rnd_err", 32'(err), 32'(m_err));
            for (int j = 0; j < P; j++) begin
                if (dst[j] >= 0 && win[dst[j]] == j) begin
                    g_sent[j]++;
                    if (g_sent[j] == g_len[j]) g_len[j] = 0;
                end
            end
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
